// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_xcvr slice.
// Parity/FSM enums, RX FIFO entry layout and baud divider helper.
package uart_pkg;

  localparam int MaxDataBits = 9;

  typedef enum logic [1:0] {
    ParityNone,
    ParityEven,
    ParityOdd
  } parity_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop,
    RxWaitHigh
  } rx_state_e;

  typedef struct packed {
    logic [MaxDataBits-1:0] data;
    logic                   parity_err;
    logic                   frame_err;
  } rx_entry_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO for received UART entries.
// Push is accepted when not full or when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = cnt == (AW+1)'(Depth);
  assign empty    = cnt == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised UART transceiver, TX serialiser plus
// RX deserialiser feeding a small receive FIFO.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int      ClockFrequency = 50_000_000,
  parameter int      BaudRate       = 115_200,
  parameter int      DataBits       = 8,
  parameter parity_e Parity         = ParityNone,
  parameter int      StopBits       = 1,
  parameter int      RxFifoDepth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_valid_i,
  input  logic [DataBits-1:0] tx_data_i,
  output logic                tx_ready_o,
  output logic                uart_tx_o,
  input  logic                uart_rx_i,
  output logic                rx_valid_o,
  output logic [DataBits-1:0] rx_data_o,
  input  logic                rx_ready_i,
  output logic                rx_parity_err_o,
  output logic                rx_frame_err_o,
  output logic                rx_overflow_o
);

  localparam int ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
  localparam int CW         = $clog2(ClksPerBit);
  localparam int BW         = $clog2(DataBits + 1);
  localparam logic OddPar   = (Parity == ParityOdd);

  // ---------------- TX ----------------
  tx_state_e           tx_state, tx_state_d;
  logic [CW-1:0]       tx_cnt, tx_cnt_d;
  logic [BW-1:0]       tx_bit, tx_bit_d;
  logic [DataBits-1:0] tx_sh, tx_sh_d;
  logic                tx_par, tx_par_d;
  logic                tx_line, tx_line_d;
  logic                tx_last;
  logic                tx_stop_end;
  logic                tx_accept;

  assign tx_last     = tx_cnt == CW'(ClksPerBit - 1);
  assign tx_stop_end = (tx_state == TxStop) && tx_last &&
                       (tx_bit == BW'(StopBits - 1));
  assign tx_ready_o  = (tx_state == TxIdle) || tx_stop_end;
  assign tx_accept   = tx_valid_i && tx_ready_o;
  assign uart_tx_o   = tx_line;

  // TX state register; the line flop resets high asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_par   <= tx_par_d;
      tx_line  <= tx_line_d;
    end
  end

  // TX next state; accepting in the last stop cycle keeps frames gapless
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_last ? '0 : tx_cnt + 1'b1;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_par_d   = tx_par;
    if (tx_accept) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_sh_d    = tx_data_i;
      tx_par_d   = (^tx_data_i) ^ OddPar;
    end else begin
      unique case (tx_state)
        TxIdle: tx_cnt_d = '0;
        TxStart: begin
          if (tx_last) begin
            tx_state_d = TxData;
            tx_bit_d   = '0;
          end
        end
        TxData: begin
          if (tx_last) begin
            tx_sh_d  = tx_sh >> 1;
            tx_bit_d = tx_bit + 1'b1;
            if (tx_bit == BW'(DataBits - 1)) begin
              tx_bit_d   = '0;
              tx_state_d = (Parity == ParityNone) ? TxStop : TxParity;
            end
          end
        end
        TxParity: begin
          if (tx_last) begin
            tx_state_d = TxStop;
            tx_bit_d   = '0;
          end
        end
        TxStop: begin
          if (tx_last) tx_bit_d = tx_bit + 1'b1;
          if (tx_stop_end) tx_state_d = TxIdle;
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  // TX line value for the upcoming cycle, registered to avoid glitches
  always_comb begin
    tx_line_d = 1'b1;
    unique case (tx_state_d)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_sh_d[0];
      TxParity: tx_line_d = tx_par_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic                rx_s1, rx_s2, rxs, rxs_q;
  rx_state_e           rx_state, rx_state_d;
  logic [CW-1:0]       rx_cnt, rx_cnt_d;
  logic [BW-1:0]       rx_bit, rx_bit_d;
  logic [DataBits-1:0] rx_sh, rx_sh_d;
  logic                rx_perr, rx_perr_d;
  logic                rx_last;
  logic                rx_half;
  logic                push_q, push_d;
  rx_entry_t           ent_q, ent_d;

  assign rxs     = rx_s2;
  assign rx_last = rx_cnt == CW'(ClksPerBit - 1);
  assign rx_half = rx_cnt == CW'(ClksPerBit / 2 - 1);

  // input synchroniser, previous-sample flop and RX state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rxs_q    <= 1'b1;
      rx_state <= RxIdle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      push_q   <= 1'b0;
      ent_q    <= '0;
    end else begin
      rx_s1    <= uart_rx_i;
      rx_s2    <= rx_s1;
      rxs_q    <= rxs;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_perr  <= rx_perr_d;
      push_q   <= push_d;
      ent_q    <= ent_d;
    end
  end

  // RX next state; a high start sample is treated as a glitch
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_last ? '0 : rx_cnt + 1'b1;
    rx_bit_d   = rx_bit;
    unique case (rx_state)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rxs_q && !rxs) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxs ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_last) begin
          rx_bit_d = rx_bit + 1'b1;
          if (rx_bit == BW'(DataBits - 1))
            rx_state_d = (Parity == ParityNone) ? RxStop : RxParity;
        end
      end
      RxParity: if (rx_last) rx_state_d = RxStop;
      RxStop:   if (rx_last) rx_state_d = rxs ? RxIdle : RxWaitHigh;
      RxWaitHigh: begin
        rx_cnt_d = '0;
        if (rxs) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX datapath: shift samples in, check parity, build the entry
  always_comb begin
    rx_sh_d          = rx_sh;
    rx_perr_d        = rx_perr;
    push_d           = 1'b0;
    ent_d            = '0;
    ent_d.data       = MaxDataBits'(rx_sh);
    ent_d.parity_err = rx_perr;
    ent_d.frame_err  = !rxs;
    unique case (rx_state)
      RxStart:  rx_perr_d = 1'b0;
      RxData:   if (rx_last) rx_sh_d = {rxs, rx_sh[DataBits-1:1]};
      RxParity: if (rx_last) rx_perr_d = rxs ^ (^rx_sh) ^ OddPar;
      RxStop:   push_d = rx_last;
      default:  ;
    endcase
  end

  // ---------------- FIFO ----------------
  rx_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      ovf_q;
  logic      unused_head;

  assign pop = rx_valid_o && rx_ready_i;

  uart_rx_fifo #(
    .Width($bits(rx_entry_t)),
    .Depth(RxFifoDepth)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push_q),
    .push_data(ent_q),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid_o      = !fifo_empty;
  assign rx_data_o       = head.data[DataBits-1:0];
  assign rx_parity_err_o = head.parity_err;
  assign rx_frame_err_o  = head.frame_err;
  assign rx_overflow_o   = ovf_q;
  assign unused_head     = ^head.data;

  // flag a dropped frame for exactly one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= push_q && fifo_full && !pop;
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed bench for uart_xcvr, ClksPerBit = 10.
// One 8N1 instance (TX, overflow, glitch) and one 8E2 (loopback, errors).
module tb_uart_xcvr;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx_valid1 = 1'b0, tx_ready1, tx1, rx1_drv = 1'b1;
  logic [7:0] tx_data1 = '0, rx_data1;
  logic       rx_valid1, rx_ready1 = 1'b0, perr1, ferr1, ovf1;

  logic       tx_valid2 = 1'b0, tx_ready2, tx2, rx2, rx2_drv = 1'b1;
  logic [7:0] tx_data2 = '0, rx_data2;
  logic       rx_valid2, rx_ready2 = 1'b0, perr2, ferr2, ovf2;
  logic       lb = 1'b0;

  assign rx2 = lb ? tx2 : rx2_drv;

  uart_xcvr #(
    .ClockFrequency(1_000_000), .BaudRate(100_000), .DataBits(8),
    .Parity(ParityNone), .StopBits(1), .RxFifoDepth(4)
  ) d1 (
    .clk_i(clk), .rst_i(rst),
    .tx_valid_i(tx_valid1), .tx_data_i(tx_data1), .tx_ready_o(tx_ready1),
    .uart_tx_o(tx1), .uart_rx_i(rx1_drv),
    .rx_valid_o(rx_valid1), .rx_data_o(rx_data1), .rx_ready_i(rx_ready1),
    .rx_parity_err_o(perr1), .rx_frame_err_o(ferr1), .rx_overflow_o(ovf1)
  );

  uart_xcvr #(
    .ClockFrequency(1_000_000), .BaudRate(100_000), .DataBits(8),
    .Parity(ParityEven), .StopBits(2), .RxFifoDepth(4)
  ) d2 (
    .clk_i(clk), .rst_i(rst),
    .tx_valid_i(tx_valid2), .tx_data_i(tx_data2), .tx_ready_o(tx_ready2),
    .uart_tx_o(tx2), .uart_rx_i(rx2),
    .rx_valid_o(rx_valid2), .rx_data_o(rx_data2), .rx_ready_i(rx_ready2),
    .rx_parity_err_o(perr2), .rx_frame_err_o(ferr2), .rx_overflow_o(ovf2)
  );

  int total = 0;
  int bad   = 0;
  int ovf_cnt = 0;

  always @(negedge clk) if (ovf1) ovf_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_line(input bit sel, input logic v, input int n);
    if (sel) rx2_drv = v;
    else     rx1_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input bit sel, input logic [7:0] d,
                           input int par, input logic stopv,
                           input int stopn);
    rx_line(sel, 1'b0, 10);
    for (int i = 0; i < 8; i++) rx_line(sel, d[i], 10);
    if (par >= 0) rx_line(sel, par[0], 10);
    rx_line(sel, stopv, stopn);
  endtask

  task automatic pop1(input string tag, input logic [7:0] exp);
    check({tag, "_v"}, rx_valid1, 1);
    check({tag, "_d"}, rx_data1, exp);
    rx_ready1 = 1'b1;
    @(negedge clk);
    rx_ready1 = 1'b0;
  endtask

  task automatic pop2(input string tag, input logic [7:0] exp,
                      input logic pe, input logic fe);
    int k = 0;
    while (!rx_valid2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_v"}, rx_valid2, 1);
    check({tag, "_d"}, rx_data2, exp);
    check({tag, "_pe"}, perr2, pe);
    check({tag, "_fe"}, ferr2, fe);
    rx_ready2 = 1'b1;
    @(negedge clk);
    rx_ready2 = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    int k;
    a5 = 8'hA5;

    // reset state
    @(negedge clk);
    check("rst_tx", tx1, 1);
    check("rst_rdy", tx_ready1, 1);
    check("rst_rxv", rx_valid1, 0);
    check("rst_ovf", ovf1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-frame of 0x55
    tx_data1 = 8'h55; tx_valid1 = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    repeat (24) @(negedge clk);
    check("mid_tx_low", tx1, 0);
    #2 rst = 1'b1;
    #1 check("async_tx", tx1, 1);
    check("async_rdy", tx_ready1, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rdy", tx_ready1, 1);
    check("post_tx", tx1, 1);
    check("post_rxv", rx_valid1, 0);
    repeat (3) @(negedge clk);

    // TX 8N1 of 0xA5
    tx_data1 = a5; tx_valid1 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      logic e;
      @(negedge clk);
      if (i == 1) tx_valid1 = 1'b0;
      if (i <= 10)      e = 1'b0;
      else if (i <= 90) e = a5[(i - 11) / 10];
      else              e = 1'b1;
      check($sformatf("tx_bit%0d", i), tx1, e);
      if (i == 99)  check("tx_rdy99", tx_ready1, 0);
      if (i == 100) check("tx_rdy100", tx_ready1, 1);
    end
    @(negedge clk);
    check("tx_idle", tx1, 1);

    // loopback 8E2, back-to-back
    lb = 1'b1;
    repeat (5) @(negedge clk);
    tx_data2 = 8'h3C; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_data2 = 8'h81;
    k = 1;
    while (!tx_ready2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("lb_frame_len", k, 120);
    @(negedge clk);
    tx_valid2 = 1'b0;
    pop2("lb0", 8'h3C, 1'b0, 1'b0);
    pop2("lb1", 8'h81, 1'b0, 1'b0);
    repeat (130) @(negedge clk);
    lb = 1'b0;
    repeat (10) @(negedge clk);

    // parity error and framing error on 8E2
    send_bits(1'b1, 8'h3C, 1, 1'b1, 20);
    pop2("perr", 8'h3C, 1'b1, 1'b0);
    send_bits(1'b1, 8'h12, 0, 1'b0, 30);
    rx_line(1'b1, 1'b1, 50);
    pop2("ferr", 8'h12, 1'b0, 1'b1);
    check("ferr_single", rx_valid2, 0);

    // overflow on 8N1, consumer stalled
    for (int i = 1; i <= 4; i++) send_bits(1'b0, 8'(i), -1, 1'b1, 20);
    check("ovf_none4", ovf_cnt, 0);
    send_bits(1'b0, 8'h05, -1, 1'b1, 20);
    check("ovf_one", ovf_cnt, 1);
    for (int i = 1; i <= 4; i++) pop1($sformatf("ovf_pop%0d", i), 8'(i));
    check("ovf_empty", rx_valid1, 0);

    // glitch is ignored
    rx_line(1'b0, 1'b0, 3);
    rx_line(1'b0, 1'b1, 30);
    check("glitch", rx_valid1, 0);

    // full FIFO with a pop in the push cycle
    for (int i = 0; i < 4; i++)
      send_bits(1'b0, 8'h11 + 8'(i), -1, 1'b1, 20);
    check("full_ovf", ovf_cnt, 1);
    send_bits(1'b0, 8'h15, -1, 1'b1, 8);
    check("fp_head", rx_data1, 8'h11);
    rx_ready1 = 1'b1;
    @(negedge clk);
    rx_ready1 = 1'b0;
    rx_line(1'b0, 1'b1, 10);
    check("fp_no_ovf", ovf_cnt, 1);
    for (int i = 0; i < 4; i++)
      pop1($sformatf("fp_pop%0d", i), 8'h12 + 8'(i));
    check("fp_empty", rx_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
